// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core/dbg requester ports and data-memory port of dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req_i;
  logic              core_we_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic [2:0]        core_ctrl_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic              core_stall_o;

  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic [2:0]        dbg_ctrl_i;
  logic              dbg_lock_i;
  logic              dbg_gnt_o;
  logic              dbg_rvalid_o;

  logic [DATA_W-1:0] rdata_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [2:0]        mem_ctrl_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i, core_ctrl_i,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_ctrl_i, dbg_lock_i,
    input  mem_rdata_i,
    output core_gnt_o, core_rvalid_o, core_stall_o,
    output dbg_gnt_o, dbg_rvalid_o,
    output rdata_o, mem_addr_o, mem_wdata_o, mem_ctrl_o, mem_we_o, busy_o
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i, core_ctrl_i,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_ctrl_i, dbg_lock_i,
    output mem_rdata_i,
    input  core_gnt_o, core_rvalid_o, core_stall_o,
    input  dbg_gnt_o, dbg_rvalid_o,
    input  rdata_o, mem_addr_o, mem_wdata_o, mem_ctrl_o, mem_we_o, busy_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin core/dbg arbiter for the single data-memory port
// Optional DMEM_ARB_LOCK_EN: dbg_lock_i lets the last dbg winner keep priority.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input logic          clk_i,
  input logic          rst_ni,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic              last_dbg_q;
  logic              port_dbg_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        ctrl_q;
  logic [3:0]        cnt_q;
  logic              core_gnt_q, dbg_gnt_q;
  logic              core_rv_q, dbg_rv_q;
  logic [DATA_W-1:0] rdata_q;

  logic start, sel_dbg, final_cyc, in_access, lock_win;

`ifdef DMEM_ARB_LOCK_EN
  assign lock_win = last_dbg_q & bus.dbg_lock_i;
`else
  logic unused_lock;
  assign unused_lock = bus.dbg_lock_i;
  assign lock_win    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    sel_dbg   = 1'b0;
    final_cyc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.core_req_i || bus.dbg_req_i) begin
          start = 1'b1;
          // on a tie the port that lost last time wins, unless dbg holds its lock
          if (bus.core_req_i && bus.dbg_req_i) sel_dbg = lock_win | ~last_dbg_q;
          else                                 sel_dbg = bus.dbg_req_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          final_cyc = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_dbg_q <= 1'b1;
      port_dbg_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= 3'b000;
      cnt_q      <= 4'd0;
      core_gnt_q <= 1'b0;
      dbg_gnt_q  <= 1'b0;
      core_rv_q  <= 1'b0;
      dbg_rv_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      core_gnt_q <= start & ~sel_dbg;
      dbg_gnt_q  <= start & sel_dbg;
      core_rv_q  <= final_cyc & ~port_dbg_q;
      dbg_rv_q   <= final_cyc & port_dbg_q;
      if (start) begin
        port_dbg_q <= sel_dbg;
        last_dbg_q <= sel_dbg;
        we_q       <= sel_dbg ? bus.dbg_we_i    : bus.core_we_i;
        addr_q     <= sel_dbg ? bus.dbg_addr_i  : bus.core_addr_i;
        wdata_q    <= sel_dbg ? bus.dbg_wdata_i : bus.core_wdata_i;
        ctrl_q     <= sel_dbg ? bus.dbg_ctrl_i  : bus.core_ctrl_i;
        cnt_q      <= WS_INIT;
      end else if (in_access && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (final_cyc && !we_q) rdata_q <= bus.mem_rdata_i;
    end
  end

  assign in_access = (state_q == ACCESS);

  assign bus.mem_addr_o    = in_access ? addr_q  : '0;
  assign bus.mem_wdata_o   = in_access ? wdata_q : '0;
  assign bus.mem_ctrl_o    = in_access ? ctrl_q  : 3'b000;
  assign bus.mem_we_o      = final_cyc & we_q;
  assign bus.busy_o        = in_access;
  assign bus.rdata_o       = rdata_q;
  assign bus.core_gnt_o    = core_gnt_q;
  assign bus.dbg_gnt_o     = dbg_gnt_q;
  assign bus.core_rvalid_o = core_rv_q;
  assign bus.dbg_rvalid_o  = dbg_rv_q;
  // stall is forced low while reset is asserted so every output reads 0
  assign bus.core_stall_o  = rst_ni & ((bus.core_req_i & ~core_gnt_q) | (in_access & ~port_dbg_q));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a reference model
module tb_dmem_arbiter;
  localparam int WS   = 1;
  localparam int NCYC = 400;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  assign b0.mem_rdata_i = mem0[b0.mem_addr_o[5:2]];
  assign b1.mem_rdata_i = mem1[b1.mem_addr_o[5:2]];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(WS)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0))  u1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // memory writes are applied just before the edge that ends the write cycle
  task automatic tick();
    if (b0.mem_we_o) mem0[b0.mem_addr_o[5:2]] = b0.mem_wdata_o;
    if (b1.mem_we_o) mem1[b1.mem_addr_o[5:2]] = b1.mem_wdata_o;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] outs0();
    return b0.mem_addr_o | b0.mem_wdata_o | b0.rdata_o |
           {22'b0, b0.mem_ctrl_o, b0.mem_we_o, b0.busy_o, b0.core_gnt_o, b0.dbg_gnt_o,
            b0.core_rvalid_o, b0.dbg_rvalid_o, b0.core_stall_o};
  endfunction

  bit gp [4];
  int gc [4];
  int ng;

  // both ports keep requesting, dropping req only in their own grant cycle
  task automatic collect(input int n, input bit use_core, input int drop_lock_at);
    ng = 0;
    b0.core_req_i = use_core;
    b0.dbg_req_i  = 1'b1;
    for (int k = 1; k <= 40 && ng < n; k++) begin
      tick();
      if (b0.core_gnt_o) begin gp[ng] = 1'b0; gc[ng] = k; ng++; end
      else if (b0.dbg_gnt_o) begin gp[ng] = 1'b1; gc[ng] = k; ng++; end
      if (ng == drop_lock_at) b0.dbg_lock_i = 1'b0;
      b0.core_req_i = use_core && !b0.core_gnt_o && ng < n;
      b0.dbg_req_i  = !b0.dbg_gnt_o && ng < n;
    end
    b0.core_req_i = 1'b0;
    b0.dbg_req_i  = 1'b0;
    check("grant_count", 32'(ng), 32'(n));
  endtask

  // reference model schedule, indexed by cycle
  bit          e_g0 [NCYC+8], e_g1 [NCYC+8], e_r0 [NCYC+8], e_r1 [NCYC+8];
  bit          e_we [NCYC+8], e_busy [NCYC+8], e_cfly [NCYC+8], e_ld [NCYC+8];
  logic [31:0] e_addr [NCYC+8], e_wd [NCYC+8], e_ldv [NCYC+8];
  logic [2:0]  e_ctrl [NCYC+8];
  logic [31:0] mmem [16];

  initial begin
    logic [7:0]  gv, rv;
    logic [31:0] a, d, mrd;
    logic [2:0]  c;
    bit          we, w, exp_stall;
    int          free, n1;
    bit          last_dbg;

    rst_n = 1'b0;
    b0.core_req_i = 0; b0.core_we_i = 0; b0.core_addr_i = 0; b0.core_wdata_i = 0; b0.core_ctrl_i = 0;
    b0.dbg_req_i = 0; b0.dbg_we_i = 0; b0.dbg_addr_i = 0; b0.dbg_wdata_i = 0; b0.dbg_ctrl_i = 0;
    b0.dbg_lock_i = 0;
    b1.core_req_i = 0; b1.core_we_i = 0; b1.core_addr_i = 0; b1.core_wdata_i = 0; b1.core_ctrl_i = 0;
    b1.dbg_req_i = 0; b1.dbg_we_i = 0; b1.dbg_addr_i = 0; b1.dbg_wdata_i = 0; b1.dbg_ctrl_i = 0;
    b1.dbg_lock_i = 0;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 32'h1000_0000 + 32'(i);
      mem1[i] = 32'h2000_0000 + 32'(i);
    end
    mem0[4] = 32'hDEAD_BEEF;
    mem1[2] = 32'hCAFE_F00D;
    #1;
    check("reset_outputs", outs0(), 32'h0);
    tick();
    check("reset_outputs_clk", outs0(), 32'h0);
    rst_n = 1'b1;
    tick();

    // core load alone
    b0.core_req_i = 1; b0.core_we_i = 0; b0.core_addr_i = 32'h10; b0.core_ctrl_i = 3'b010;
    #1;
    check("ld_stall_c0", 32'(b0.core_stall_o), 32'h1);
    tick();
    check("ld_gnt_c1", 32'(b0.core_gnt_o), 32'h1);
    check("ld_addr_c1", b0.mem_addr_o, 32'h10);
    check("ld_stall_c1", 32'(b0.core_stall_o), 32'h1);
    b0.core_req_i = 0;
    tick();
    check("ld_gnt_c2", 32'(b0.core_gnt_o), 32'h0);
    check("ld_addr_c2", b0.mem_addr_o, 32'h10);
    check("ld_stall_c2", 32'(b0.core_stall_o), 32'h1);
    check("ld_we_c2", 32'(b0.mem_we_o), 32'h0);
    tick();
    check("ld_rvalid_c3", 32'(b0.core_rvalid_o), 32'h1);
    check("ld_rdata_c3", b0.rdata_o, 32'hDEAD_BEEF);
    check("ld_stall_c3", 32'(b0.core_stall_o), 32'h0);
    check("ld_addr_idle", b0.mem_addr_o, 32'h0);

    // dbg store alone
    b0.dbg_req_i = 1; b0.dbg_we_i = 1; b0.dbg_addr_i = 32'h20; b0.dbg_wdata_i = 32'hA5; b0.dbg_ctrl_i = 3'b010;
    tick();
    check("st_gnt_c1", 32'(b0.dbg_gnt_o), 32'h1);
    check("st_we_c1", 32'(b0.mem_we_o), 32'h0);
    b0.dbg_req_i = 0;
    tick();
    check("st_we_c2", 32'(b0.mem_we_o), 32'h1);
    check("st_addr_c2", b0.mem_addr_o, 32'h20);
    check("st_wdata_c2", b0.mem_wdata_o, 32'hA5);
    check("st_ctrl_c2", 32'(b0.mem_ctrl_o), 32'h2);
    tick();
    check("st_we_c3", 32'(b0.mem_we_o), 32'h0);
    check("st_rvalid_c3", 32'(b0.dbg_rvalid_o), 32'h1);
    check("st_core_rvalid_c3", 32'(b0.core_rvalid_o), 32'h0);
    check("st_rdata_kept", b0.rdata_o, 32'hDEAD_BEEF);
    check("st_mem_written", mem0[8], 32'hA5);
    b0.dbg_we_i = 0;

    // both requesting continuously from reset
    reset_pulse();
    collect(4, 1'b1, 99);
    for (int i = 0; i < 4; i++) check($sformatf("alt_port%0d", i), 32'(gp[i]), 32'(i % 2));
    check("alt_first_cycle", 32'(gc[0]), 32'h1);
    for (int i = 0; i < 3; i++) check($sformatf("alt_spacing%0d", i), 32'(gc[i+1] - gc[i]), 32'(WS + 2));
    repeat (4) tick();

    // zero wait states, back-to-back core loads
    gv = 0; rv = 0; n1 = 0;
    b1.core_req_i = 1; b1.core_addr_i = 32'h8; b1.core_ctrl_i = 3'b010;
    for (int k = 1; k < 8; k++) begin
      tick();
      gv[k] = b1.core_gnt_o;
      rv[k] = b1.core_rvalid_o;
      if (b1.core_gnt_o) n1++;
      if (k == 6) check("ws0_rdata", b1.rdata_o, 32'hCAFE_F00D);
      b1.core_req_i = !b1.core_gnt_o && n1 < 3;
    end
    b1.core_req_i = 0;
    check("ws0_gnt_cycles", 32'(gv), 32'h2A);
    check("ws0_rvalid_cycles", 32'(rv), 32'h54);

    // reset in the middle of a core store
    b0.core_req_i = 1; b0.core_we_i = 1; b0.core_addr_i = 32'h30; b0.core_wdata_i = 32'h1234_5678;
    tick();
    check("rst_st_gnt", 32'(b0.core_gnt_o), 32'h1);
    b0.core_req_i = 0; b0.core_we_i = 0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", outs0(), 32'h0);
    tick();
    check("rst_mid_outs_held", outs0(), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_mid_no_write", mem0[12], 32'h1000_000C);
    check("rst_mid_no_rvalid", 32'(b0.core_rvalid_o | b0.dbg_rvalid_o), 32'h0);
    b0.core_req_i = 1; b0.dbg_req_i = 1;
    tick();
    check("rst_core_first", 32'({b0.core_gnt_o, b0.dbg_gnt_o}), 32'h2);
    b0.core_req_i = 0; b0.dbg_req_i = 0;
    repeat (4) tick();

    // dbg lock after a dbg grant
    reset_pulse();
    collect(1, 1'b0, 99);
    check("lock_pre_dbg", 32'(gp[0]), 32'h1);
    b0.dbg_lock_i = 1;
    collect(4, 1'b1, 3);
    for (int i = 0; i < 4; i++)
      check($sformatf("lock_port%0d", i), 32'(gp[i]), LOCK ? 32'(i < 3) : 32'(i % 2 == 0 ? 0 : 1));
    b0.dbg_lock_i = 0;
    repeat (4) tick();

    // randomized traffic against the cycle-scheduled reference model
    reset_pulse();
    for (int i = 0; i < 16; i++) mmem[i] = mem0[i];
    for (int k = 0; k < NCYC + 8; k++) begin
      e_g0[k] = 0; e_g1[k] = 0; e_r0[k] = 0; e_r1[k] = 0; e_we[k] = 0; e_busy[k] = 0;
      e_cfly[k] = 0; e_ld[k] = 0; e_addr[k] = 0; e_wd[k] = 0; e_ldv[k] = 0; e_ctrl[k] = 0;
    end
    free = 0; last_dbg = 1'b1; mrd = 0;
    for (int k = 0; k < NCYC; k++) begin
      if (e_ld[k]) mrd = e_ldv[k];
      exp_stall = (b0.core_req_i && !e_g0[k]) || e_cfly[k];
      check($sformatf("r_cgnt@%0d", k), 32'(b0.core_gnt_o), 32'(e_g0[k]));
      check($sformatf("r_dgnt@%0d", k), 32'(b0.dbg_gnt_o), 32'(e_g1[k]));
      check($sformatf("r_crv@%0d", k), 32'(b0.core_rvalid_o), 32'(e_r0[k]));
      check($sformatf("r_drv@%0d", k), 32'(b0.dbg_rvalid_o), 32'(e_r1[k]));
      check($sformatf("r_we@%0d", k), 32'(b0.mem_we_o), 32'(e_we[k]));
      check($sformatf("r_busy@%0d", k), 32'(b0.busy_o), 32'(e_busy[k]));
      check($sformatf("r_stall@%0d", k), 32'(b0.core_stall_o), 32'(exp_stall));
      check($sformatf("r_addr@%0d", k), b0.mem_addr_o, e_addr[k]);
      check($sformatf("r_wdata@%0d", k), b0.mem_wdata_o, e_wd[k]);
      check($sformatf("r_ctrl@%0d", k), 32'(b0.mem_ctrl_o), 32'(e_ctrl[k]));
      check($sformatf("r_rdata@%0d", k), b0.rdata_o, mrd);

      if (e_g0[k]) b0.core_req_i = 0;
      else if (!b0.core_req_i && k < NCYC - 12 && $urandom_range(0, 2) == 0) begin
        b0.core_req_i = 1; b0.core_we_i = 1'($urandom_range(0, 1));
        b0.core_addr_i = $urandom; b0.core_wdata_i = $urandom; b0.core_ctrl_i = 3'($urandom_range(0, 7));
      end
      if (e_g1[k]) b0.dbg_req_i = 0;
      else if (!b0.dbg_req_i && k < NCYC - 12 && $urandom_range(0, 2) == 0) begin
        b0.dbg_req_i = 1; b0.dbg_we_i = 1'($urandom_range(0, 1));
        b0.dbg_addr_i = $urandom; b0.dbg_wdata_i = $urandom; b0.dbg_ctrl_i = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 7) == 0) b0.dbg_lock_i = !b0.dbg_lock_i;

      if (k >= free && (b0.core_req_i || b0.dbg_req_i)) begin
        if (b0.core_req_i && b0.dbg_req_i) w = (LOCK && last_dbg && b0.dbg_lock_i) ? 1'b1 : !last_dbg;
        else w = b0.dbg_req_i;
        a  = w ? b0.dbg_addr_i  : b0.core_addr_i;
        d  = w ? b0.dbg_wdata_i : b0.core_wdata_i;
        c  = w ? b0.dbg_ctrl_i  : b0.core_ctrl_i;
        we = w ? b0.dbg_we_i    : b0.core_we_i;
        if (w) e_g1[k+1] = 1; else e_g0[k+1] = 1;
        for (int j = k + 1; j <= k + 1 + WS; j++) begin
          e_busy[j] = 1; e_addr[j] = a; e_wd[j] = d; e_ctrl[j] = c;
          if (!w) e_cfly[j] = 1;
        end
        if (we) begin
          e_we[k+1+WS] = 1;
          mmem[a[5:2]] = d;
        end else begin
          e_ld[k+2+WS]  = 1;
          e_ldv[k+2+WS] = mmem[a[5:2]];
        end
        if (w) e_r1[k+2+WS] = 1; else e_r0[k+2+WS] = 1;
        last_dbg = w;
        free = k + 2 + WS;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
